// File: rtl/line_edit_pkg.sv
// Shared types and constants for the line-editing controller.
package line_edit_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2
  } le_state_t;

  localparam logic [7:0] LE_CR = 8'h0D;

  // Winner of the per-cycle event priority encoder.
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_ENTER  = 3'd1,
    EV_DELETE = 3'd2,
    EV_BKSP   = 3'd3,
    EV_LEFT   = 3'd4,
    EV_RIGHT  = 3'd5,
    EV_CHAR   = 3'd6
  } le_ev_t;

  // Number of event strobes raised in one cycle.
  function automatic logic [2:0] ev_count(input logic [5:0] ev);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, ev[i]};
    return n;
  endfunction

endpackage

// File: rtl/line_edit_if.sv
// Byte-stream valid/ready handshake from the line editor to its consumer.
interface line_edit_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/line_edit_buf.sv
// Line buffer: DEPTH bytes with insert-at (shift up), remove-at (shift down)
// and a combinational read port. Data storage is not reset.
module line_edit_buf #(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_ins,
  input  logic          i_rm,
  input  logic [PW-1:0] i_pos,
  input  logic [7:0]    i_din,
  input  logic [PW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data
);

  logic [DEPTH*8-1:0] r_mem;
  logic [DEPTH*8-1:0] w_up;
  logic [DEPTH*8-1:0] w_dn;

  // Neighbour views: byte i of w_up is byte i-1, byte i of w_dn is byte i+1.
  assign w_up = {r_mem[DEPTH*8-9:0], 8'h00};
  assign w_dn = {8'h00, r_mem[DEPTH*8-1:8]};

  // Insert opens a gap at i_pos; remove closes the gap at i_pos.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_ins) begin
        if (PW'(i) == i_pos)     r_mem[i*8 +: 8] <= i_din;
        else if (PW'(i) > i_pos) r_mem[i*8 +: 8] <= w_up[i*8 +: 8];
      end else if (i_rm && (PW'(i) >= i_pos)) begin
        r_mem[i*8 +: 8] <= w_dn[i*8 +: 8];
      end
    end
  end

  // Read mux for the streaming index.
  always_comb begin
    o_rd_data = 8'h00;
    for (int i = 0; i < DEPTH; i++)
      if (PW'(i) == i_rd_idx) o_rd_data = r_mem[i*8 +: 8];
  end

endmodule

// File: rtl/line_edit_ctrl.sv
// Line-editing controller: edits a line buffer from decoded key events and
// streams the finished line plus CR over a valid/ready handshake on Enter.
module line_edit_ctrl
  import line_edit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          char_valid,
  input  logic [7:0]    char_in,
  input  logic          left_cursor,
  input  logic          right_cursor,
  input  logic          Backspace,
  input  logic          Delete,
  input  logic          Enter,
  line_edit_if.master   bus,
  output logic [PW-1:0] cursor_pos,
  output logic [PW-1:0] line_len,
  output logic          busy,
  output logic          overflow,
  output logic          dropped
);

  le_state_t     r_state, w_state_n;
  logic [PW-1:0] r_len, w_len_n;
  logic [PW-1:0] r_cur, w_cur_n;
  logic [PW-1:0] r_idx, w_idx_n;
  logic [PW-1:0] w_pos;
  logic          r_ovf, w_ovf_n;
  logic          r_drop, w_drop_n;
  logic          w_ins, w_rm, w_hs;
  le_ev_t        w_sel;
  logic [2:0]    w_nev;
  logic [7:0]    w_rd_data;

  line_edit_buf #(.DEPTH(DEPTH), .PW(PW)) u_buf (
    .clk       (clk),
    .i_ins     (w_ins),
    .i_rm      (w_rm),
    .i_pos     (w_pos),
    .i_din     (char_in),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data)
  );

  // Outputs depend on registered state only, never on out_ready.
  assign bus.out_valid = (r_state != EDIT);
  assign bus.out_data  = (r_state == TERM) ? LE_CR :
                         (r_state == SEND) ? w_rd_data : 8'h00;
  assign w_hs          = (r_state != EDIT) && bus.out_ready;
  assign busy          = (r_state != EDIT);
  assign cursor_pos    = r_cur;
  assign line_len      = r_len;
  assign overflow      = r_ovf;
  assign dropped       = r_drop;

  // Priority encoder: Enter > Delete > Backspace > left > right > char.
  always_comb begin
    w_nev = ev_count({Enter, Delete, Backspace, left_cursor, right_cursor, char_valid});
    if (Enter)             w_sel = EV_ENTER;
    else if (Delete)       w_sel = EV_DELETE;
    else if (Backspace)    w_sel = EV_BKSP;
    else if (left_cursor)  w_sel = EV_LEFT;
    else if (right_cursor) w_sel = EV_RIGHT;
    else if (char_valid)   w_sel = EV_CHAR;
    else                   w_sel = EV_NONE;
  end

  // Control registers; asynchronous reset returns to an empty idle line.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= EDIT;
      r_len   <= '0;
      r_cur   <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_cur   <= w_cur_n;
      r_idx   <= w_idx_n;
      r_ovf   <= w_ovf_n;
      r_drop  <= w_drop_n;
    end
  end

  // Next-state, edit commands and status pulses.
  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_cur_n   = r_cur;
    w_idx_n   = r_idx;
    w_pos     = r_cur;
    w_ins     = 1'b0;
    w_rm      = 1'b0;
    w_ovf_n   = 1'b0;
    w_drop_n  = 1'b0;
    case (r_state)
      EDIT: begin
        w_drop_n = (w_nev > 3'd1);
        case (w_sel)
          EV_ENTER: begin
            w_idx_n   = '0;
            w_state_n = (r_len == '0) ? TERM : SEND;
          end
          EV_DELETE: if (r_cur < r_len) begin
            w_rm    = 1'b1;
            w_len_n = r_len - PW'(1);
          end
          EV_BKSP: if (r_cur != '0) begin
            w_rm    = 1'b1;
            w_pos   = r_cur - PW'(1);
            w_len_n = r_len - PW'(1);
            w_cur_n = r_cur - PW'(1);
          end
          EV_LEFT:  if (r_cur != '0)   w_cur_n = r_cur - PW'(1);
          EV_RIGHT: if (r_cur < r_len) w_cur_n = r_cur + PW'(1);
          EV_CHAR: begin
            if (r_len == PW'(DEPTH)) begin
              w_ovf_n = 1'b1;
            end else begin
              w_ins   = 1'b1;
              w_len_n = r_len + PW'(1);
              w_cur_n = r_cur + PW'(1);
            end
          end
          default: ;
        endcase
      end
      SEND: begin
        w_drop_n = (w_nev != 3'd0);
        if (w_hs) begin
          if (r_idx == r_len - PW'(1)) w_state_n = TERM;
          else                         w_idx_n   = r_idx + PW'(1);
        end
      end
      TERM: begin
        w_drop_n = (w_nev != 3'd0);
        if (w_hs) begin
          w_len_n   = '0;
          w_cur_n   = '0;
          w_state_n = EDIT;
        end
      end
      default: w_state_n = EDIT;
    endcase
  end

endmodule

// File: tb/tb_line_edit_ctrl.sv
// Self-checking bench for line_edit_ctrl: directed scenarios followed by
// random key sequences, checked against a queue-based model of the line.
module tb_line_edit_ctrl;

  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          char_valid = 1'b0;
  logic [7:0]    char_in = 8'h00;
  logic          left_cursor = 1'b0;
  logic          right_cursor = 1'b0;
  logic          Backspace = 1'b0;
  logic          Delete = 1'b0;
  logic          Enter = 1'b0;
  logic [PW-1:0] cursor_pos, line_len;
  logic          busy, overflow, dropped;

  int checks = 0;
  int failures = 0;

  byte unsigned mq[$];
  int           mcur = 0;

  line_edit_if u_if();

  line_edit_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .char_valid   (char_valid),
    .char_in      (char_in),
    .left_cursor  (left_cursor),
    .right_cursor (right_cursor),
    .Backspace    (Backspace),
    .Delete       (Delete),
    .Enter        (Enter),
    .bus          (u_if),
    .cursor_pos   (cursor_pos),
    .line_len     (line_len),
    .busy         (busy),
    .overflow     (overflow),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One edit-cycle: drive strobes, clock, then compare against the model.
  task automatic do_ev(input bit e, input bit d, input bit b, input bit l,
                       input bit r, input bit c, input logic [7:0] ch);
    int  n;
    bit  eovf;
    n = int'(e) + int'(d) + int'(b) + int'(l) + int'(r) + int'(c);
    eovf = 1'b0;
    Enter = e; Delete = d; Backspace = b;
    left_cursor = l; right_cursor = r; char_valid = c; char_in = ch;
    @(posedge clk); #1;
    Enter = 0; Delete = 0; Backspace = 0;
    left_cursor = 0; right_cursor = 0; char_valid = 0;
    if (e) begin
    end else if (d) begin
      if (mcur < mq.size()) mq.delete(mcur);
    end else if (b) begin
      if (mcur > 0) begin mq.delete(mcur - 1); mcur--; end
    end else if (l) begin
      if (mcur > 0) mcur--;
    end else if (r) begin
      if (mcur < mq.size()) mcur++;
    end else if (c) begin
      if (mq.size() == DEPTH) eovf = 1'b1;
      else begin mq.insert(mcur, ch); mcur++; end
    end
    chk("line_len", line_len, mq.size());
    chk("cursor_pos", cursor_pos, mcur);
    chk("overflow", overflow, eovf);
    chk("dropped", dropped, (n > 1));
    chk("busy_after_ev", busy, e);
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) do_ev(0, 0, 0, 0, 0, 1, s[i]);
  endtask

  // Drain the line after Enter; with rnd, stall randomly and poke events while busy.
  task automatic send_line(input bit rnd);
    byte unsigned exp[$];
    int  k, guard;
    bit  rdy, inj;
    exp = mq;
    exp.push_back(8'h0D);
    k = 0;
    guard = 0;
    while (k < exp.size() && guard < 400) begin
      chk("busy", busy, 1);
      chk("out_valid", u_if.out_valid, 1);
      chk("out_data", u_if.out_data, exp[k]);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      inj = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      u_if.out_ready = rdy;
      left_cursor = inj;
      @(posedge clk); #1;
      u_if.out_ready = 1'b0;
      left_cursor = 1'b0;
      chk("dropped_busy", dropped, inj);
      if (rdy) k++;
      guard++;
    end
    chk("send_count", k, exp.size());
    mq.delete();
    mcur = 0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", u_if.out_valid, 0);
    chk("idle_len", line_len, 0);
    chk("idle_cursor", cursor_pos, 0);
  endtask

  initial begin
    u_if.out_ready = 1'b0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_len", line_len, 0);
    chk("rst_cursor", cursor_pos, 0);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_data", u_if.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped, 0);
    Reset = 1'b0;

    // Basic line and send
    type_str("ABC");
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(0);

    // Insert mid-line, backspace, delete
    type_str("ABC");
    do_ev(0, 0, 0, 1, 0, 0, 8'h00);
    do_ev(0, 0, 0, 1, 0, 0, 8'h00);
    do_ev(0, 0, 0, 0, 0, 1, "X");
    chk("axbc_cursor", cursor_pos, 2);
    do_ev(0, 0, 1, 0, 0, 0, 8'h00);
    chk("bksp_cursor", cursor_pos, 1);
    do_ev(0, 1, 0, 0, 0, 0, 8'h00);
    chk("del_len", line_len, 2);
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(0);

    // Boundary no-ops
    do_ev(0, 0, 0, 1, 0, 0, 8'h00);
    do_ev(0, 0, 1, 0, 0, 0, 8'h00);
    type_str("Q");
    do_ev(0, 0, 0, 0, 1, 0, 8'h00);
    do_ev(0, 1, 0, 0, 0, 0, 8'h00);
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(0);

    // Full buffer then overflow
    type_str("0123456789abcdef");
    do_ev(0, 0, 0, 0, 0, 1, 8'h5A);
    chk("full_len", line_len, 16);
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(0);

    // Enter with a simultaneous char
    type_str("AB");
    do_ev(1, 0, 0, 0, 0, 1, "Z");
    send_line(0);

    // Stalled stream
    type_str("AB");
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(1);

    // Reset mid-send
    type_str("HELLO");
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk("mid_send_data", u_if.out_data, "E");
    Reset = 1'b1;
    #1;
    chk("arst_valid", u_if.out_valid, 0);
    chk("arst_len", line_len, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cursor", cursor_pos, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    mq.delete();
    mcur = 0;

    // Empty line
    do_ev(1, 0, 0, 0, 0, 0, 8'h00);
    send_line(0);

    // Random key sequences
    for (int t = 0; t < 300; t++) begin
      int          sel;
      logic [7:0]  ch;
      bit          e, d, b, l, r, c;
      sel = $urandom_range(0, 99);
      ch  = 8'($urandom_range(32, 126));
      {e, d, b, l, r, c} = 6'b0;
      if (sel < 55)      c = 1'b1;
      else if (sel < 63) l = 1'b1;
      else if (sel < 71) r = 1'b1;
      else if (sel < 79) b = 1'b1;
      else if (sel < 87) d = 1'b1;
      else if (sel < 92) e = 1'b1;
      else begin
        {e, d, b, l, r, c} = 6'($urandom_range(0, 63));
        if ((int'(e) + int'(d) + int'(b) + int'(l) + int'(r) + int'(c)) < 2) begin
          l = 1'b1; c = 1'b1;
        end
      end
      do_ev(e, d, b, l, r, c, ch);
      if (e) send_line(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
